// File: rtl/if_id_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage_reg_pkg
// Brief    : Shared encodings for the IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
package if_id_stage_reg_pkg;

    localparam int unsigned OPCODE_MSB    = 15;
    localparam int unsigned OPCODE_LSB    = 11;
    localparam int unsigned OPCODE_W      = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [15:0]         NOP_INSTR_DEF = 16'h0800;
    localparam logic [OPCODE_W-1:0] HALT_OP_DEF   = 5'b00000;

    localparam int unsigned ST_W      = 1;
    localparam logic [ST_W-1:0] ST_RUN    = 1'b0;
    localparam logic [ST_W-1:0] ST_HALTED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/if_id_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_id_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage_reg
// Brief    : IF/ID pipeline register with stall hold, bubble injection, HALT freeze.
// Revision : 1.0
// ============================================================================
module if_id_stage_reg
    import if_id_stage_reg_pkg::*;
#(
    parameter int unsigned          INSTR_W   = 16,
    parameter int unsigned          PC_W      = 16,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [OPCODE_W-1:0]  HALT_OP   = HALT_OP_DEF,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc2_in,
    input  logic               imem_done,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc2_out,
    output logic               valid_out,
    output logic               pc_write_en,
    output logic               halt_seen,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [INSTR_W-1:0]  r_instr;
    logic [PC_W-1:0]     r_pc2;
    logic                r_valid;
    logic [ST_W-1:0]     r_state;
    logic [ST_W-1:0]     w_state_nxt;
    logic [OPCODE_W-1:0] w_opcode;
    logic                w_halt_at_decode;
    logic                w_cnt_inc;
    logic                w_cnt_clear;

    assign w_opcode         = r_instr[OPCODE_MSB:OPCODE_LSB];
    assign w_halt_at_decode = r_valid && (w_opcode == HALT_OP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_halt_at_decode && !stall && !flush) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // Only a redirect can cancel a HALT fetched down a wrong path.
                if (flush) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr <= NOP_INSTR;
            r_pc2   <= '0;
            r_valid <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (stall) begin
                r_instr <= r_instr;
                r_valid <= r_valid;
            end else if ((r_state == ST_HALTED) || !imem_done) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else begin
                r_instr <= instr_in;
                r_pc2   <= pc2_in;
                r_valid <= 1'b1;
            end
        end
    end

    // A flush carries the redirect target, so the PC must take it regardless.
    assign pc_write_en = flush || (!stall && imem_done && (r_state == ST_RUN));

    assign w_cnt_inc   = stall && !flush;
    assign w_cnt_clear = !rst;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (w_cnt_clear),
        .inc   (w_cnt_inc),
        .count (stall_cnt)
    );

    assign instr_out = r_instr;
    assign pc2_out   = r_pc2;
    assign valid_out = r_valid;
    assign halt_seen = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage_reg
// Brief    : Directed vector bench for if_id_stage_reg (stall counter at 4 bits).
// Revision : 1.0
// ============================================================================
module tb_if_id_stage_reg;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [15:0]      instr_in;
    logic [15:0]      pc2_in;
    logic             imem_done;
    logic             stall;
    logic             flush;
    logic [15:0]      instr_out;
    logic [15:0]      pc2_out;
    logic             valid_out;
    logic             pc_write_en;
    logic             halt_seen;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    if_id_stage_reg #(
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .pc2_in      (pc2_in),
        .imem_done   (imem_done),
        .stall       (stall),
        .flush       (flush),
        .instr_out   (instr_out),
        .pc2_out     (pc2_out),
        .valid_out   (valid_out),
        .pc_write_en (pc_write_en),
        .halt_seen   (halt_seen),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        done;
        logic        stall;
        logic        flush;
        logic        chk_pcw;
        logic        e_pcw;
        logic [15:0] e_instr;
        logic [15:0] e_pc2;
        logic        e_valid;
        logic        e_halt;
        logic [3:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [15:0] i, input logic [15:0] p,
                         input logic d, input logic s, input logic f);
        rst       = r;
        instr_in  = i;
        pc2_in    = p;
        imem_done = d;
        stall     = s;
        flush     = f;
    endtask

    task automatic check_regs(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                              input logic ev, input logic eh, input logic [3:0] ec);
        chk({tag, ".instr_out"}, instr_out, ei);
        chk({tag, ".pc2_out"},   pc2_out,   ep);
        chk({tag, ".valid_out"}, {15'd0, valid_out}, {15'd0, ev});
        chk({tag, ".halt_seen"}, {15'd0, halt_seen}, {15'd0, eh});
        chk({tag, ".stall_cnt"}, {12'd0, stall_cnt}, {12'd0, ec});
    endtask

    initial begin
        //               rst   instr     pc2       done  stall flush chkp  pcw   e_instr   e_pc2     ev    eh    cnt
        vecs[0]  = '{1'b0, 16'h4001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 16'h4001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0800, 16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 16'h4001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4001, 16'h0002, 1'b1, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 16'hC123, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hC123, 16'h0004, 1'b1, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 16'hC125, 16'h0006, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hC123, 16'h0004, 1'b1, 1'b0, 4'd1};
        vecs[5]  = '{1'b1, 16'hC125, 16'h0006, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hC123, 16'h0004, 1'b1, 1'b0, 4'd2};
        vecs[6]  = '{1'b1, 16'hC125, 16'h0006, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hC123, 16'h0004, 1'b1, 1'b0, 4'd3};
        vecs[7]  = '{1'b1, 16'h8A00, 16'h0006, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8A00, 16'h0006, 1'b1, 1'b0, 4'd3};
        vecs[8]  = '{1'b1, 16'h9999, 16'h0008, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0006, 1'b0, 1'b0, 4'd3};
        vecs[9]  = '{1'b1, 16'h2468, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2468, 16'h0010, 1'b1, 1'b0, 4'd3};
        vecs[10] = '{1'b1, 16'h1357, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0800, 16'h0010, 1'b0, 1'b0, 4'd3};
        vecs[11] = '{1'b1, 16'h1357, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0800, 16'h0010, 1'b0, 1'b0, 4'd3};
        vecs[12] = '{1'b1, 16'h1357, 16'h0012, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1357, 16'h0012, 1'b1, 1'b0, 4'd3};
        vecs[13] = '{1'b1, 16'h0000, 16'h0014, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0014, 1'b1, 1'b0, 4'd3};
        // HALT is in decode during this edge: FSM goes HALTED, the following fetch still lands.
        vecs[14] = '{1'b1, 16'h5555, 16'h0016, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 16'h0016, 1'b1, 1'b1, 4'd3};
        vecs[15] = '{1'b1, 16'h6666, 16'h0018, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0800, 16'h0016, 1'b0, 1'b1, 4'd3};
        vecs[16] = '{1'b1, 16'h6666, 16'h0018, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0800, 16'h0016, 1'b0, 1'b1, 4'd3};
        vecs[17] = '{1'b1, 16'h7777, 16'h0020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0016, 1'b0, 1'b0, 4'd3};
        vecs[18] = '{1'b1, 16'h7777, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7777, 16'h0020, 1'b1, 1'b0, 4'd3};

        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        #1;

        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].rst, vecs[v].instr, vecs[v].pc2,
                  vecs[v].done, vecs[v].stall, vecs[v].flush);
            #2;
            if (vecs[v].chk_pcw) begin
                chk($sformatf("v%0d.pc_write_en", v), {15'd0, pc_write_en}, {15'd0, vecs[v].e_pcw});
            end
            @(posedge clk);
            #1;
            check_regs($sformatf("v%0d", v), vecs[v].e_instr, vecs[v].e_pc2,
                       vecs[v].e_valid, vecs[v].e_halt, vecs[v].e_cnt);
        end

        // Long stall: counter climbs from 3 and must stick at 4'hF.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'h1111, 16'h0022, 1'b1, 1'b1, 1'b0);
            #2;
            chk($sformatf("sat%0d.pc_write_en", i), {15'd0, pc_write_en}, 16'd0);
            @(posedge clk);
            #1;
            check_regs($sformatf("sat%0d", i), 16'h7777, 16'h0020, 1'b1, 1'b0,
                       (3 + i + 1 > 15) ? 4'hF : 4'(3 + i + 1));
        end

        // Reset mid-stall discards content and clears the counter.
        drive(1'b0, 16'h1111, 16'h0022, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_regs("midrst", 16'h0800, 16'h0000, 1'b0, 1'b0, 4'd0);

        drive(1'b1, 16'hABCD, 16'h0030, 1'b1, 1'b0, 1'b0);
        #2;
        chk("resume.pc_write_en", {15'd0, pc_write_en}, 16'd1);
        @(posedge clk);
        #1;
        check_regs("resume", 16'hABCD, 16'h0030, 1'b1, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
